// File: rtl/axi_write_master.sv
// -----------------------------------------------------------------------------
// axi_write_master
//
// Purpose
//   AXI4 write initiator. It takes one burst command at a time and issues one
//   AW request. It streams the payload from a local data port as INCR W beats,
//   collects the B response, and then pulses a one-cycle completion strobe.
//   Before any AXI traffic is issued, a command is rejected locally if its
//   start address is not aligned to the beat size or if the burst would cross
//   a 4 KB boundary.
//
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready     command handshake
//   i_cmd_addr/i_cmd_len/i_cmd_id burst start byte address, beats-1, AXI ID
//   i_wd_valid / o_wd_ready       payload beat handshake
//   i_wd_data                     payload beat data
//   o_done_valid, o_done_resp     one-cycle completion pulse and its response
//                                 (the B resp, or 2'b10 for a local reject or
//                                 a B ID mismatch)
//   o_aw_*                        AXI AW channel (fields latched from the command)
//   o_w_*, i_w_ready              AXI W channel (passed through from the wd port)
//   i_b_*, o_b_ready              AXI B channel
//   o_dbg_state                   current FSM state, for debug visibility
//
// Handshake rule used on every channel: a transfer happens on a rising clk
// edge where valid and ready are both 1. A valid source keeps its payload
// stable until that edge. A ready signal may depend combinationally on the
// other side's valid.
// -----------------------------------------------------------------------------
module axi_write_master #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 64,
  parameter int ID_WIDTH      = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  // command port
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0]  i_cmd_addr,
  input  logic [7:0]                i_cmd_len,
  input  logic [ID_WIDTH-1:0]       i_cmd_id,
  // payload port
  input  logic                      i_wd_valid,
  output logic                      o_wd_ready,
  input  logic [DATA_WIDTH-1:0]     i_wd_data,
  // completion
  output logic                      o_done_valid,
  output logic [1:0]                o_done_resp,
  // AW channel
  output logic [ID_WIDTH-1:0]       o_aw_id,
  output logic [ADDRESS_WIDTH-1:0]  o_aw_addr,
  output logic [7:0]                o_aw_len,
  output logic [2:0]                o_aw_size,
  output logic [1:0]                o_aw_burst,
  output logic [3:0]                o_aw_cache,
  output logic [2:0]                o_aw_prot,
  output logic [3:0]                o_aw_qos,
  output logic [3:0]                o_aw_region,
  output logic                      o_aw_valid,
  input  logic                      i_aw_ready,
  // W channel
  output logic [DATA_WIDTH-1:0]     o_w_data,
  output logic [DATA_WIDTH/8-1:0]   o_w_strb,
  output logic                      o_w_last,
  output logic                      o_w_valid,
  input  logic                      i_w_ready,
  // B channel
  input  logic [1:0]                i_b_resp,
  input  logic [ID_WIDTH-1:0]       i_b_id,
  input  logic                      i_b_valid,
  output logic                      o_b_ready,
  // debug
  output logic [1:0]                o_dbg_state
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // Beat size in bytes is a power of two of at least 2 (DATA_WIDTH >= 16).
  localparam int SIZE_LOG2  = $clog2(STRB_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BURST  = 2'd1,
    S_WAIT_B = 2'd2,
    S_REJECT = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;

  logic [ADDRESS_WIDTH-1:0]   r_aw_addr;
  logic [7:0]                 r_aw_len;
  logic [ID_WIDTH-1:0]        r_aw_id;
  logic                       r_aw_valid;
  logic                       r_aw_done;
  logic                       r_w_done;
  logic [7:0]                 r_beat_cnt;
  logic                       r_b_ready;
  logic                       r_done_valid;
  logic [1:0]                 r_done_resp;

  logic                       w_cmd_fire;
  logic                       w_unaligned;
  logic [31:0]                w_burst_end;
  logic                       w_crosses_4k;
  logic                       w_cmd_bad;
  logic                       w_in_burst;
  logic                       w_w_valid;
  logic                       w_w_last;
  logic                       w_w_fire;
  logic                       w_aw_fire;
  logic                       w_b_fire;
  logic                       w_aw_done_nx;
  logic                       w_w_done_nx;

  // ---------------------------------------------------------------------------
  // Command screening. The end offset is computed within the 4 KB page. A
  // burst that ends exactly on the page boundary (end == 4096) is still legal.
  // ---------------------------------------------------------------------------
  assign w_cmd_fire   = i_cmd_valid & o_cmd_ready;
  assign w_unaligned  = |i_cmd_addr[SIZE_LOG2-1:0];
  assign w_burst_end  = 32'(i_cmd_addr[11:0])
                      + ((32'(i_cmd_len) + 32'd1) * 32'(STRB_WIDTH));
  assign w_crosses_4k = (w_burst_end > 32'd4096);
  assign w_cmd_bad    = w_unaligned | w_crosses_4k;

  // ---------------------------------------------------------------------------
  // Channel handshakes. The W channel is a zero-bubble pass-through of the wd
  // port. It is gated off once the last beat has been sent.
  // ---------------------------------------------------------------------------
  assign w_in_burst   = (r_state == S_BURST);
  assign w_w_valid    = w_in_burst & i_wd_valid & ~r_w_done;
  assign w_w_last     = w_in_burst & (r_beat_cnt == r_aw_len);
  assign w_w_fire     = w_w_valid & i_w_ready;
  assign w_aw_fire    = r_aw_valid & i_aw_ready;
  assign w_b_fire     = r_b_ready & i_b_valid;

  // AW and the final W beat may complete in either order or in the same cycle.
  assign w_aw_done_nx = r_aw_done | w_aw_fire;
  assign w_w_done_nx  = r_w_done | (w_w_fire & w_w_last);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          w_next_state = w_cmd_bad ? S_REJECT : S_BURST;
        end
      end
      S_BURST: begin
        if (w_aw_done_nx && w_w_done_nx) begin
          w_next_state = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (w_b_fire) begin
          w_next_state = S_IDLE;
        end
      end
      S_REJECT: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered datapath and channel controls
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aw_addr    <= '0;
      r_aw_len     <= '0;
      r_aw_id      <= '0;
      r_aw_valid   <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_beat_cnt   <= '0;
      r_b_ready    <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_resp  <= 2'b00;
    end else begin
      r_done_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_aw_addr  <= i_cmd_addr;
            r_aw_len   <= i_cmd_len;
            r_aw_id    <= i_cmd_id;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_beat_cnt <= '0;
            if (w_cmd_bad) begin
              // The pulse is visible during the single REJECT cycle.
              r_done_valid <= 1'b1;
              r_done_resp  <= 2'b10;
            end else begin
              r_aw_valid <= 1'b1;
            end
          end
        end
        S_BURST: begin
          if (w_aw_fire) begin
            r_aw_valid <= 1'b0;
            r_aw_done  <= 1'b1;
          end
          if (w_w_fire) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_w_last) begin
              r_w_done <= 1'b1;
            end
          end
          if (w_aw_done_nx && w_w_done_nx) begin
            r_b_ready <= 1'b1;
          end
        end
        S_WAIT_B: begin
          if (w_b_fire) begin
            r_b_ready    <= 1'b0;
            r_done_valid <= 1'b1;
            r_done_resp  <= (i_b_id != r_aw_id) ? 2'b10 : i_b_resp;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_wd_ready   = w_in_burst & i_w_ready & ~r_w_done;
  assign o_done_valid = r_done_valid;
  assign o_done_resp  = r_done_resp;

  assign o_aw_id      = r_aw_id;
  assign o_aw_addr    = r_aw_addr;
  assign o_aw_len     = r_aw_len;
  assign o_aw_size    = 3'(SIZE_LOG2);
  assign o_aw_burst   = 2'b01;
  assign o_aw_cache   = 4'd0;
  assign o_aw_prot    = 3'd0;
  assign o_aw_qos     = 4'd0;
  assign o_aw_region  = 4'd0;
  assign o_aw_valid   = r_aw_valid;

  assign o_w_data     = i_wd_data;
  assign o_w_strb     = '1;
  assign o_w_last     = w_w_last;
  assign o_w_valid    = w_w_valid;

  assign o_b_ready    = r_b_ready;
  assign o_dbg_state  = r_state;

endmodule
